// File: rtl/packet_parser.sv
// Receive-side inband packet parser: decodes header and timestamp words of fixed
// 256-word packets, forwards payload words to one channel FIFO and discards padding.
module packet_parser #(
    parameter int MAX_PAYLOAD_BYTES = 504
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        chan_full,
    output logic [8:0]  payload_length,
    output logic [3:0]  tag,
    output logic [4:0]  chan_number,
    output logic [5:0]  rssi,
    output logic        start_burst,
    output logic        end_burst,
    output logic        dropped_packet,
    output logic        underrun,
    output logic        overrun,
    output logic [31:0] timestamp,
    output logic        header_valid,
    output logic        chan_wr,
    output logic [15:0] chan_data,
    output logic        packet_done,
    output logic        length_error,
    output logic        fifo_overflow,
    output logic [7:0]  word_count
);

    localparam logic [8:0] MAX_LEN = 9'(MAX_PAYLOAD_BYTES);

    typedef enum logic [2:0] {
        S_HDR1,
        S_HDR2,
        S_TS1,
        S_TS2,
        S_PAYLOAD,
        S_PAD
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pw;
    logic [7:0] pay_cnt;
    logic       len_err;

    logic [8:0] raw_len;
    logic [8:0] clamped_len;
    logic [7:0] pw_new;
    logic       len_err_new;
    logic       last_word;
    logic       last_payload;

    // Header word 1 decode, used only when the HDR1 word is accepted.
    assign raw_len      = in_data[8:0];
    assign clamped_len  = (raw_len > MAX_LEN) ? MAX_LEN : raw_len;
    assign pw_new       = 8'(clamped_len >> 1) + {7'd0, clamped_len[0]};
    assign len_err_new  = (raw_len > MAX_LEN) || (in_data[15:13] != 3'b000);
    assign last_word    = (word_count == 8'hFF);
    assign last_payload = ((pay_cnt + 8'd1) == pw);

    always_comb begin
        // NOTE: default assigned first so every path drives state_next and no latch is inferred.
        state_next = state;
        if (flush) begin
            state_next = S_HDR1;
        end else if (in_valid) begin
            if (last_word) begin
                state_next = S_HDR1;
            end else begin
                case (state)
                    S_HDR1:    state_next = S_HDR2;
                    S_HDR2:    state_next = S_TS1;
                    S_TS1:     state_next = S_TS2;
                    S_TS2:     state_next = (pw != 8'd0) ? S_PAYLOAD : S_PAD;
                    S_PAYLOAD: state_next = last_payload ? S_PAD : S_PAYLOAD;
                    S_PAD:     state_next = S_PAD;
                    default:   state_next = S_HDR1;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_HDR1;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count     <= 8'd0;
            pay_cnt        <= 8'd0;
            pw             <= 8'd0;
            len_err        <= 1'b0;
            payload_length <= 9'd0;
            tag            <= 4'd0;
            chan_number    <= 5'd0;
            rssi           <= 6'd0;
            start_burst    <= 1'b0;
            end_burst      <= 1'b0;
            dropped_packet <= 1'b0;
            underrun       <= 1'b0;
            overrun        <= 1'b0;
            timestamp      <= 32'd0;
            header_valid   <= 1'b0;
            length_error   <= 1'b0;
            chan_wr        <= 1'b0;
            chan_data      <= 16'd0;
            packet_done    <= 1'b0;
            fifo_overflow  <= 1'b0;
        end else begin
            header_valid  <= 1'b0;
            length_error  <= 1'b0;
            chan_wr       <= 1'b0;
            packet_done   <= 1'b0;
            fifo_overflow <= 1'b0;

            if (flush) begin
                word_count <= 8'd0;
                pay_cnt    <= 8'd0;
            end else if (in_valid) begin
                word_count  <= word_count + 8'd1;
                packet_done <= last_word;
                case (state)
                    S_HDR1: begin
                        tag            <= in_data[12:9];
                        payload_length <= clamped_len;
                        pw             <= pw_new;
                        len_err        <= len_err_new;
                    end
                    S_HDR2: begin
                        chan_number    <= in_data[4:0];
                        rssi           <= in_data[10:5];
                        start_burst    <= in_data[11];
                        end_burst      <= in_data[12];
                        dropped_packet <= in_data[13];
                        underrun       <= in_data[14];
                        overrun        <= in_data[15];
                    end
                    S_TS1: begin
                        timestamp[15:0] <= in_data;
                    end
                    S_TS2: begin
                        timestamp[31:16] <= in_data;
                        header_valid     <= 1'b1;
                        length_error     <= len_err;
                        pay_cnt          <= 8'd0;
                    end
                    S_PAYLOAD: begin
                        // A dropped word still consumes one slot of the payload count.
                        pay_cnt <= pay_cnt + 8'd1;
                        if (chan_full) begin
                            fifo_overflow <= 1'b1;
                        end else begin
                            chan_wr   <= 1'b1;
                            chan_data <= in_data;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_packet_parser.sv
// Scoreboard bench for packet_parser: a packet-level model queues expected events,
// a monitor pops and compares them whenever the parser raises a strobe.
module tb_packet_parser;

    localparam int MAXB = 504;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        chan_full;
    logic [8:0]  payload_length;
    logic [3:0]  tag;
    logic [4:0]  chan_number;
    logic [5:0]  rssi;
    logic        start_burst, end_burst, dropped_packet, underrun, overrun;
    logic [31:0] timestamp;
    logic        header_valid, chan_wr, packet_done, length_error, fifo_overflow;
    logic [15:0] chan_data;
    logic [7:0]  word_count;

    packet_parser #(.MAX_PAYLOAD_BYTES(MAXB)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .chan_full(chan_full), .payload_length(payload_length), .tag(tag),
        .chan_number(chan_number), .rssi(rssi), .start_burst(start_burst),
        .end_burst(end_burst), .dropped_packet(dropped_packet), .underrun(underrun),
        .overrun(overrun), .timestamp(timestamp), .header_valid(header_valid),
        .chan_wr(chan_wr), .chan_data(chan_data), .packet_done(packet_done),
        .length_error(length_error), .fifo_overflow(fifo_overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {EV_HDR, EV_WR, EV_OVF, EV_DONE} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        logic [15:0] data;
        logic [8:0]  len;
        logic [3:0]  tag;
        logic [4:0]  chan;
        logic [5:0]  rssi;
        logic [4:0]  flags;
        logic [31:0] ts;
        logic        len_err;
        logic        wr_with_done;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic ev_t mk_ev(input ev_kind_t k, input logic [15:0] d);
        ev_t e;
        e.kind = k; e.data = d; e.len = '0; e.tag = '0; e.chan = '0; e.rssi = '0;
        e.flags = '0; e.ts = '0; e.len_err = 1'b0; e.wr_with_done = 1'b0;
        return e;
    endfunction

    // Packet-level reference: what a parser must emit for the first n words of a packet.
    function automatic void predict(input logic [15:0] h1, input logic [15:0] h2,
                                    input logic [15:0] ts1, input logic [15:0] ts2,
                                    input logic [255:0] full, input logic [15:0] base, input int n);
        int  raw = int'(h1[8:0]);
        int  len = (raw > MAXB) ? MAXB : raw;
        int  pw  = (len + 1) / 2;
        ev_t e;
        if (n >= 4) begin
            e = mk_ev(EV_HDR, 16'h0);
            e.len = 9'(len); e.tag = h1[12:9]; e.chan = h2[4:0]; e.rssi = h2[10:5];
            e.flags = h2[15:11]; e.ts = {ts2, ts1};
            e.len_err = (raw > MAXB) || (h1[15:13] != 3'b000);
            exp_q.push_back(e);
        end
        for (int i = 0; i < pw; i++) begin
            if (4 + i < n) begin
                if (full[4 + i]) exp_q.push_back(mk_ev(EV_OVF, 16'h0));
                else             exp_q.push_back(mk_ev(EV_WR, base + 16'(i)));
            end
        end
        if (n == 256) begin
            e = mk_ev(EV_DONE, 16'h0);
            e.wr_with_done = (pw == 252) && !full[255];
            exp_q.push_back(e);
        end
    endfunction

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_word(input logic [15:0] d, input logic f);
        in_valid = 1'b1; in_data = d; chan_full = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0; chan_full = 1'b0;
    endtask

    task automatic send_packet(input logic [15:0] h1, input logic [15:0] h2,
                               input logic [15:0] ts1, input logic [15:0] ts2,
                               input logic [255:0] full, input logic [15:0] base,
                               input int gap_max, input int n);
        logic [15:0] w;
        predict(h1, h2, ts1, ts2, full, base, n);
        for (int idx = 0; idx < n; idx++) begin
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            case (idx)
                0:       w = h1;
                1:       w = h2;
                2:       w = ts1;
                3:       w = ts2;
                default: w = base + 16'(idx - 4);
            endcase
            drive_word(w, full[idx]);
        end
    endtask

    function automatic logic [255:0] rand_full();
        logic [255:0] m;
        for (int i = 0; i < 256; i++) m[i] = ($urandom_range(0, 7) == 0);
        return m;
    endfunction

    // Monitor: pops one expected event per observed strobe, in HDR, WR/OVF, DONE order.
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (length_error && !header_valid) check("length_error_without_header", length_error, 1'b0);
                if (header_valid) begin
                    if (exp_q.size() == 0) check("spurious_header_valid", header_valid, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        check("event_order_hdr", EV_HDR, e.kind);
                        check("payload_length", payload_length, e.len);
                        check("tag", tag, e.tag);
                        check("chan_number", chan_number, e.chan);
                        check("rssi", rssi, e.rssi);
                        check("flags", {overrun, underrun, dropped_packet, end_burst, start_burst}, e.flags);
                        check("timestamp", timestamp, e.ts);
                        check("length_error", length_error, e.len_err);
                    end
                end
                if (chan_wr && fifo_overflow) check("wr_and_overflow_together", fifo_overflow, 1'b0);
                if (chan_wr || fifo_overflow) begin
                    if (exp_q.size() == 0) check("spurious_payload_strobe", 1'b1 & (chan_wr | fifo_overflow), 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        check("event_order_payload", chan_wr ? EV_WR : EV_OVF, e.kind);
                        if (chan_wr && e.kind == EV_WR) check("chan_data", chan_data, e.data);
                    end
                end
                if (packet_done) begin
                    if (exp_q.size() == 0) check("spurious_packet_done", packet_done, 1'b0);
                    else begin
                        e = exp_q.pop_front();
                        check("event_order_done", EV_DONE, e.kind);
                        check("word_count_at_done", word_count, 8'd0);
                        check("chan_wr_with_done", chan_wr, e.wr_with_done);
                    end
                end
            end
        end
    end

    logic [15:0] rh1[3], rh2[3], rt1[3], rt2[3], rbase[3];
    logic [255:0] rfull[3];
    logic [255:0] ovf_mask;

    initial begin : stimulus
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0; chan_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_word_count", word_count, 8'd0);
        check("reset_fields", {payload_length, tag, chan_number, rssi, timestamp}, 64'd0);
        check("reset_strobes", {header_valid, chan_wr, packet_done, length_error, fifo_overflow}, 5'd0);
        check("reset_chan_data", chan_data, 16'd0);
        reset = 1'b1;
        idle(2);

        // Basic packet: len 8, tag 1, chan 3, rssi 1, overrun.
        send_packet(16'h0208, 16'h8023, 16'h0001, 16'h0002, '0, 16'h00A0, 0, 256);
        idle(2);
        check("basic_chan", chan_number, 5'd3);
        check("basic_rssi", rssi, 6'd1);
        check("basic_overrun", overrun, 1'b1);
        check("basic_timestamp", timestamp, 32'h0002_0001);
        check("basic_tag", tag, 4'd1);

        // Odd, empty, maximum and oversize lengths, back to back.
        send_packet(16'h0007, 16'h1234, 16'h1111, 16'h2222, '0, 16'(($urandom)), 0, 256);
        send_packet(16'h0000, 16'h0041, 16'h3333, 16'h4444, '0, 16'(($urandom)), 0, 256);
        send_packet(16'h01F8, 16'h0802, 16'h5555, 16'h6666, '0, 16'(($urandom)), 0, 256);
        send_packet(16'h01FF, 16'h1005, 16'h7777, 16'h8888, '0, 16'(($urandom)), 0, 256);
        idle(2);
        check("clamped_payload_length", payload_length, 9'd504);
        send_packet(16'hA00A, 16'h2006, 16'h9999, 16'hAAAA, '0, 16'(($urandom)), 0, 256);

        // Overflow on payload words 2 and 3 of 6.
        ovf_mask = '0;
        ovf_mask[6] = 1'b1; ovf_mask[7] = 1'b1;
        send_packet(16'h000C, 16'h0007, 16'hBEEF, 16'hCAFE, ovf_mask, 16'h0B00, 0, 256);

        // Random packets: gapped then gapless with identical content.
        for (int p = 0; p < 3; p++) begin
            rh1[p] = 16'($urandom_range(0, 511)) | (16'($urandom_range(0, 15)) << 9);
            rh2[p] = 16'($urandom); rt1[p] = 16'($urandom); rt2[p] = 16'($urandom);
            rbase[p] = 16'($urandom); rfull[p] = rand_full();
        end
        for (int p = 0; p < 3; p++) send_packet(rh1[p], rh2[p], rt1[p], rt2[p], rfull[p], rbase[p], 5, 256);
        for (int p = 0; p < 3; p++) send_packet(rh1[p], rh2[p], rt1[p], rt2[p], rfull[p], rbase[p], 0, 256);

        // Flush at word 100 overrides a simultaneous word.
        send_packet(16'h0064, 16'h0003, 16'h0102, 16'h0304, '0, 16'h0C00, 0, 100);
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h0406;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("word_count_after_flush", word_count, 8'd0);
        send_packet(16'h0406, 16'h0011, 16'h0506, 16'h0708, '0, 16'h0D00, 2, 256);

        // Asynchronous reset at word 50.
        send_packet(16'h0020, 16'h0012, 16'h090A, 16'h0B0C, '0, 16'h0E00, 0, 50);
        idle(2);
        reset = 1'b0;
        #2;
        check("midreset_word_count", word_count, 8'd0);
        check("midreset_fields", {payload_length, tag, chan_number, rssi, timestamp}, 64'd0);
        check("midreset_strobes", {header_valid, chan_wr, packet_done, length_error, fifo_overflow}, 5'd0);
        check("midreset_chan_data", chan_data, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);
        send_packet(16'h0210, 16'h4413, 16'h0D0E, 16'h0F10, '0, 16'h0F00, 0, 256);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/packet_parser.md
# packet_parser

Receive-side counterpart of the inband packet builder: consumes the 16-bit word stream of fixed-size 512-byte (256-word) inband packets arriving from the FX2/USB on the transmit path. It decodes the two header words and the two timestamp words into registered fields, and forwards the payload words to a single channel FIFO. It discards padding and reports framing and overflow events. It sits between the USB write interface and the per-channel TX FIFOs.

## Interface
- MAX_PAYLOAD_BYTES, 504, largest legal payload_length; larger values are clamped and flagged.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low; all state and outputs clear while low.
- flush  in  1  synchronous abort; returns to HDR1 next cycle and discards the current packet.
- in_valid  in  1  qualifies in_data; one packet word per asserted cycle.
- in_data  in  16  packet word.
- chan_full  in  1  channel FIFO cannot accept a write this cycle.
- payload_length  out  9  h1[8:0], in bytes (clamped).
- tag  out  4  h1[12:9].
- chan_number  out  5  h2[4:0].
- rssi  out  6  h2[10:5].
- start_burst, end_burst, dropped_packet, underrun, overrun  out  1 each  h2[11], h2[12], h2[13], h2[14], h2[15].
- timestamp  out  32  {ts2, ts1}.
- header_valid  out  1  one-cycle pulse: all header fields are valid and stable until the next packet's HDR1 word.
- chan_wr  out  1  write strobe to the channel FIFO.
- chan_data  out  16  payload word.
- packet_done  out  1  one-cycle pulse on acceptance of word 255.
- length_error  out  1  one-cycle pulse with header_valid when the received length exceeds MAX_PAYLOAD_BYTES or h1[15:13] != 0.
- fifo_overflow  out  1  one-cycle pulse per payload word dropped because of chan_full.
- word_count  out  8  index of the next expected word in the packet.

## Operation
- States: HDR1, HDR2, TS1, TS2, PAYLOAD, PAD. Transitions occur only on accepted words, i.e. in_valid high.
- word_count:
  - increments on every accepted word and wraps 255 -> 0.
  - The wrap always returns the FSM to HDR1, whatever the state.
- HDR1 word:
  - Latches tag.
  - Latches payload_length = min(h1[8:0], MAX_PAYLOAD_BYTES).
  - Computes payload word count pw = ceil(len/2) as (len >> 1) + len[0], 8-bit.
  - Records the error condition for later reporting.
- HDR2 word: latches channel, rssi and the five flags.
- TS1 word: latches timestamp[15:0].
- TS2 word:
  - Latches timestamp[31:16].
  - Next state is PAYLOAD if pw > 0, else PAD.
- PAYLOAD:
  - Each accepted word with chan_full low produces chan_wr = 1 and chan_data = in_data.
  - Each accepted word with chan_full high is dropped and pulses fifo_overflow. It still counts toward pw.
  - After pw payload words the FSM enters PAD.
  - Odd lengths forward the final word unmasked; the spare byte is ignored downstream.
- PAD: words are consumed without any output until word 255.
- If len = 504 (pw = 252), word 255 is the last payload word. chan_wr and packet_done then pulse together, and the FSM goes directly to HDR1.
- flush:
  - Clears the FSM and word_count.
  - Suppresses chan_wr, header_valid and packet_done in that cycle.
  - Leaves latched header fields unchanged.
  - Overrides a simultaneous in_valid.

## Timing
- All outputs are registered. Each output reflects the word accepted in the previous cycle: one cycle of latency from in_valid to chan_wr, header_valid, packet_done and the field updates.
- header_valid and length_error pulse the cycle after the TS2 word is accepted.
- Reset values:
  - FSM = HDR1, word_count = 0.
  - All fields = 0, chan_data = 0.
  - All strobes and pulses = 0.
- in_valid may be deasserted for any number of cycles mid-packet. The state holds and no strobes are produced.
- chan_full is sampled in the same cycle as the payload word's in_valid. There is no stalling and no retry.
- Back-to-back packets with in_valid continuously high are supported with no idle cycle. Word 255 of packet N and word 0 of packet N+1 land on consecutive cycles.
- An asynchronous reset asserted mid-packet drops the partial packet. The first accepted word after release is treated as HDR1.

## Test plan
- Basic packet:
  - Stimulus: h1 = 0x0208 (len 8, tag 1), h2 = 0x8023, ts 0x00010002, then 4 payload words A0..A3 and 248 pad words.
  - Required: fields chan 3, rssi 1, overrun 1, timestamp 0x00020001.
  - Required: header_valid on the cycle after word 3; 4 chan_wr pulses with A0..A3; packet_done on the cycle after word 255.
- Odd and boundary lengths:
  - len 7 -> 4 chan_wr pulses.
  - len 0 -> no chan_wr, packet_done still pulses.
  - len 504 -> 252 chan_wr pulses; the last one coincides with packet_done.
- Oversize length:
  - len 0x1FF -> payload_length = 504, length_error pulses with header_valid, 252 writes.
  - h1[15:13] = 3'b101 -> length_error pulses.
- Overflow: chan_full high for payload words 2 and 3 of 6 -> 4 chan_wr pulses (words 0, 1, 4, 5) and 2 fifo_overflow pulses; packet_done timing is unchanged.
- Gapped and back-to-back traffic: random in_valid gaps of 0-5 cycles across 3 consecutive packets -> output sequence identical to the gapless run; word_count returns to 0 at each packet_done.
- Abort:
  - flush at word 100 -> the next word parses as HDR1.
  - reset low at word 50, then release -> all outputs 0 and the next packet decodes correctly.
